// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the core
// load/store unit (requester 0) and the debug/DMA port (requester 1).
// Round-robin arbitration, a lock for atomic read-modify-write, error
// checking on alignment and range, and a registered response per requester.
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 6,
    parameter int MEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_we,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_lock,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_we,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_lock,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        LOCKED0  = 2'b01,
        LOCKED1  = 2'b10
    } lock_state_t;

    lock_state_t       lock_state_r;
    logic              last_grant_r;

    logic              rsp0_valid_r;
    logic [DATA_W-1:0] rsp0_rdata_r;
    logic              rsp0_err_r;
    logic              rsp1_valid_r;
    logic [DATA_W-1:0] rsp1_rdata_r;
    logic              rsp1_err_r;

    logic              elig0_s;
    logic              elig1_s;
    logic              grant0_s;
    logic              grant1_s;
    logic              any_grant_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic              win_we_s;
    logic [DATA_W-1:0] win_wdata_s;
    logic              win_lock_s;
    logic              win_err_s;
    logic [DATA_W-1:0] win_rsp_rdata_s;

    // Misaligned or beyond the last memory word.
    function automatic logic addr_err_f(input logic [ADDR_W-1:0] addr);
        logic [31:0] word_idx;
        word_idx = 32'(addr[ADDR_W-1:2]);
        return (addr[1:0] != 2'b00) || (word_idx >= 32'(MEM_DEPTH));
    endfunction

    // A requester may compete only if its response slot frees up this cycle.
    always_comb begin
        elig0_s = req0_valid & (~rsp0_valid_r | rsp0_ready);
        elig1_s = req1_valid & (~rsp1_valid_r | rsp1_ready);
    end

    // Pick the winner: lock owner only, otherwise round-robin on ties.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else begin
            case (lock_state_r)
                LOCKED0: begin
                    grant0_s = elig0_s;
                end
                LOCKED1: begin
                    grant1_s = elig1_s;
                end
                UNLOCKED: begin
                    if (elig0_s && elig1_s) begin
                        if (last_grant_r) begin
                            grant0_s = 1'b1;
                        end else begin
                            grant1_s = 1'b1;
                        end
                    end else begin
                        grant0_s = elig0_s;
                        grant1_s = elig1_s;
                    end
                end
                default: begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
            endcase
        end
    end

    // Route the winning request's fields; all zero when nobody wins.
    always_comb begin
        win_addr_s  = {ADDR_W{1'b0}};
        win_we_s    = 1'b0;
        win_wdata_s = {DATA_W{1'b0}};
        win_lock_s  = 1'b0;
        if (grant0_s) begin
            win_addr_s  = req0_addr;
            win_we_s    = req0_we;
            win_wdata_s = req0_wdata;
            win_lock_s  = req0_lock;
        end else if (grant1_s) begin
            win_addr_s  = req1_addr;
            win_we_s    = req1_we;
            win_wdata_s = req1_wdata;
            win_lock_s  = req1_lock;
        end else begin
            win_addr_s  = {ADDR_W{1'b0}};
            win_we_s    = 1'b0;
            win_wdata_s = {DATA_W{1'b0}};
            win_lock_s  = 1'b0;
        end
    end

    // Error flag and the read data that the response will capture.
    always_comb begin
        any_grant_s     = grant0_s | grant1_s;
        win_err_s       = addr_err_f(win_addr_s);
        win_rsp_rdata_s = {DATA_W{1'b0}};
        if (!win_we_s && !win_err_s) begin
            win_rsp_rdata_s = mem_rdata;
        end else begin
            win_rsp_rdata_s = {DATA_W{1'b0}};
        end
    end

    // Drive the memory and handshakes; erroneous writes never reach storage.
    always_comb begin
        req0_ready = grant0_s;
        req1_ready = grant1_s;
        mem_addr   = win_addr_s;
        mem_wdata  = win_wdata_s;
        mem_we     = any_grant_s & win_we_s & ~win_err_s;
    end

    // Lock FSM and round-robin pointer, advanced on every accepted access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_state_r <= UNLOCKED;
            last_grant_r <= 1'b1;
        end else if (any_grant_s) begin
            last_grant_r <= grant1_s;
            if (win_lock_s) begin
                lock_state_r <= grant1_s ? LOCKED1 : LOCKED0;
            end else begin
                lock_state_r <= UNLOCKED;
            end
        end
    end

    // Requester 0 response slot: load on accept, drain on consume.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp0_valid_r <= 1'b0;
            rsp0_rdata_r <= {DATA_W{1'b0}};
            rsp0_err_r   <= 1'b0;
        end else if (grant0_s) begin
            rsp0_valid_r <= 1'b1;
            rsp0_rdata_r <= win_rsp_rdata_s;
            rsp0_err_r   <= win_err_s;
        end else if (rsp0_ready) begin
            rsp0_valid_r <= 1'b0;
            rsp0_rdata_r <= {DATA_W{1'b0}};
            rsp0_err_r   <= 1'b0;
        end
    end

    // Requester 1 response slot: load on accept, drain on consume.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp1_valid_r <= 1'b0;
            rsp1_rdata_r <= {DATA_W{1'b0}};
            rsp1_err_r   <= 1'b0;
        end else if (grant1_s) begin
            rsp1_valid_r <= 1'b1;
            rsp1_rdata_r <= win_rsp_rdata_s;
            rsp1_err_r   <= win_err_s;
        end else if (rsp1_ready) begin
            rsp1_valid_r <= 1'b0;
            rsp1_rdata_r <= {DATA_W{1'b0}};
            rsp1_err_r   <= 1'b0;
        end
    end

    assign rsp0_valid = rsp0_valid_r;
    assign rsp0_rdata = rsp0_rdata_r;
    assign rsp0_err   = rsp0_err_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp1_rdata = rsp1_rdata_r;
    assign rsp1_err   = rsp1_err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          preload;
    logic          in_valid     [2];
    logic [AW-1:0] in_addr      [2];
    logic          in_we        [2];
    logic [DW-1:0] in_wdata     [2];
    logic          in_lock      [2];
    logic          in_rsp_ready [2];

    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (in_valid[0]),
        .req0_ready (req0_ready),
        .req0_addr  (in_addr[0]),
        .req0_we    (in_we[0]),
        .req0_wdata (in_wdata[0]),
        .req0_lock  (in_lock[0]),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (in_rsp_ready[0]),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .req1_valid (in_valid[1]),
        .req1_ready (req1_ready),
        .req1_addr  (in_addr[1]),
        .req1_we    (in_we[1]),
        .req1_wdata (in_wdata[1]),
        .req1_lock  (in_lock[1]),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (in_rsp_ready[1]),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return 32'hC0DE_0000 | 32'(i * 257);
    endfunction

    // Environment memory: 32 words so that out-of-range indices still decode.
    logic [DW-1:0] env_mem [0:31];
    assign mem_rdata = env_mem[mem_addr[AW-1:2]];

    // Preload pattern, then accept writes from the arbiter.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) env_mem[i] <= pat(i);
        end else if (mem_we) begin
            env_mem[mem_addr[AW-1:2]] <= mem_wdata;
        end
    end

    // Reference model state (transaction level).
    int            lock_owner;   // -1 = nobody holds the lock
    int            last_grant;
    logic          m_rv    [2];
    logic [DW-1:0] m_rdata [2];
    logic          m_err   [2];
    logic [DW-1:0] ref_mem [0:DEPTH-1];

    int   n_checks = 0;
    int   n_fails  = 0;
    logic obs_ready0, obs_ready1, obs_mem_we;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [AW-1:0] a);
        return ((int'(a) % 4) != 0) || ((int'(a) / 4) >= DEPTH);
    endfunction

    task automatic model_reset();
        lock_owner = -1;
        last_grant = 1;
        for (int n = 0; n < 2; n++) begin
            m_rv[n]    = 1'b0;
            m_rdata[n] = '0;
            m_err[n]   = 1'b0;
        end
    endtask

    task automatic drive(input int n, input logic v, input logic [AW-1:0] a, input logic we,
                         input logic [DW-1:0] wd, input logic lk);
        in_valid[n] = v;
        in_addr[n]  = a;
        in_we[n]    = we;
        in_wdata[n] = wd;
        in_lock[n]  = lk;
    endtask

    task automatic idle_all();
        for (int n = 0; n < 2; n++) begin
            drive(n, 1'b0, '0, 1'b0, '0, 1'b0);
            in_rsp_ready[n] = 1'b1;
        end
    endtask

    // One clock: check issue-side outputs, advance model, check responses.
    // Called at a falling edge with the inputs for this cycle already driven.
    task automatic step();
        bit  e [2];
        int  win;
        bit  werr;
        int  idx;
        #1;
        for (int n = 0; n < 2; n++) e[n] = in_valid[n] && (!m_rv[n] || in_rsp_ready[n]);
        win = -1;
        if (lock_owner >= 0) begin
            if (e[lock_owner]) win = lock_owner;
        end else if (e[0] && e[1]) begin
            win = 1 - last_grant;
        end else if (e[0]) begin
            win = 0;
        end else if (e[1]) begin
            win = 1;
        end
        obs_ready0 = req0_ready;
        obs_ready1 = req1_ready;
        obs_mem_we = mem_we;
        check_value("req0_ready", req0_ready, win == 0);
        check_value("req1_ready", req1_ready, win == 1);
        werr = 1'b0;
        idx  = 0;
        if (win >= 0) begin
            werr = addr_bad(in_addr[win]);
            idx  = int'(in_addr[win]) / 4;
            check_value("mem_we", mem_we, in_we[win] && !werr);
            check_value("mem_addr", mem_addr, in_addr[win]);
            check_value("mem_wdata", mem_wdata, in_wdata[win]);
        end else begin
            check_value("mem_we_idle", mem_we, 1'b0);
            check_value("mem_addr_idle", mem_addr, '0);
            check_value("mem_wdata_idle", mem_wdata, '0);
        end
        for (int n = 0; n < 2; n++) begin
            if (win == n) begin
                m_rv[n]    = 1'b1;
                m_err[n]   = werr;
                m_rdata[n] = (!in_we[n] && !werr) ? ref_mem[idx] : '0;
            end else if (in_rsp_ready[n]) begin
                m_rv[n] = 1'b0;
            end
        end
        if (win >= 0) begin
            if (in_we[win] && !werr) ref_mem[idx] = in_wdata[win];
            lock_owner = in_lock[win] ? win : -1;
            last_grant = win;
        end
        @(posedge clk);
        @(negedge clk);
        check_value("rsp0_valid", rsp0_valid, m_rv[0]);
        check_value("rsp1_valid", rsp1_valid, m_rv[1]);
        if (m_rv[0]) begin
            check_value("rsp0_rdata", rsp0_rdata, m_rdata[0]);
            check_value("rsp0_err", rsp0_err, m_err[0]);
        end
        if (m_rv[1]) begin
            check_value("rsp1_rdata", rsp1_rdata, m_rdata[1]);
            check_value("rsp1_err", rsp1_err, m_err[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
        model_reset();
        rst     = 1'b0;
        preload = 1'b1;
        idle_all();
        drive(0, 1'b1, 7'h08, 1'b1, 32'h1234_5678, 1'b0);
        drive(1, 1'b1, 7'h0C, 1'b1, 32'h8765_4321, 1'b0);
        @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        // Reset state
        check_value("rst_req0_ready", req0_ready, 1'b0);
        check_value("rst_req1_ready", req1_ready, 1'b0);
        check_value("rst_mem_we", mem_we, 1'b0);
        check_value("rst_rsp0_valid", rsp0_valid, 1'b0);
        check_value("rst_rsp1_valid", rsp1_valid, 1'b0);
        check_value("rst_rsp0_rdata", rsp0_rdata, 32'h0);
        check_value("rst_rsp0_err", rsp0_err, 1'b0);
        rst = 1'b1;
        idle_all();

        // Write then read back the same word.
        drive(0, 1'b1, 7'h08, 1'b1, 32'hDEAD_BEEF, 1'b0);
        step();
        check_value("t1_wr_rsp_valid", rsp0_valid, 1'b1);
        drive(0, 1'b1, 7'h08, 1'b0, 32'h0, 1'b0);
        step();
        check_value("t1_rd_rsp_valid", rsp0_valid, 1'b1);
        check_value("t1_rd_rdata", rsp0_rdata, 32'hDEAD_BEEF);
        check_value("t1_rd_err", rsp0_err, 1'b0);
        idle_all();

        // Single req1 access so requester 0 owns the next tie.
        drive(1, 1'b1, 7'h04, 1'b0, 32'h0, 1'b0);
        step();
        idle_all();

        // Continuous contention: grants alternate 0,1,0,1,0.
        drive(0, 1'b1, 7'h00, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b1, 7'h04, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_value("t2_alternate", obs_ready0, (i % 2) == 0);
        end
        idle_all();

        // Lock by req1: req0 blocked while locked, even when req1 is idle.
        drive(0, 1'b1, 7'h0C, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b1, 7'h10, 1'b0, 32'h0, 1'b1);
        step();
        check_value("t3_lock_r1", obs_ready1, 1'b1);
        check_value("t3_lock_r0", obs_ready0, 1'b0);
        drive(1, 1'b0, 7'h10, 1'b0, 32'h0, 1'b0);
        step();
        check_value("t3_idle_owner_r0", obs_ready0, 1'b0);
        drive(1, 1'b1, 7'h10, 1'b1, 32'hA5A5_0010, 1'b0);
        step();
        check_value("t3_unlock_r0", obs_ready0, 1'b0);
        check_value("t3_unlock_r1", obs_ready1, 1'b1);
        drive(1, 1'b0, 7'h00, 1'b0, 32'h0, 1'b0);
        step();
        check_value("t3_after_r0", obs_ready0, 1'b1);
        idle_all();

        // Error accesses: accepted, not written, err=1, rdata=0.
        drive(0, 1'b1, 7'h06, 1'b1, 32'hBAD0_0006, 1'b0);
        step();
        check_value("t4_mis_we", obs_mem_we, 1'b0);
        check_value("t4_mis_err", rsp0_err, 1'b1);
        check_value("t4_mis_rdata", rsp0_rdata, 32'h0);
        drive(0, 1'b1, 7'h40, 1'b1, 32'hBAD0_0040, 1'b0);
        step();
        check_value("t4_oor_we", obs_mem_we, 1'b0);
        check_value("t4_oor_err", rsp0_err, 1'b1);
        drive(0, 1'b1, 7'h40, 1'b0, 32'h0, 1'b0);
        step();
        check_value("t4_oor_rd_rdata", rsp0_rdata, 32'h0);
        drive(0, 1'b1, 7'h04, 1'b0, 32'h0, 1'b0);
        step();
        check_value("t4_word1_intact", rsp0_rdata, pat(1));
        idle_all();

        // Response backpressure on requester 0.
        in_rsp_ready[0] = 1'b0;
        drive(0, 1'b1, 7'h00, 1'b0, 32'h0, 1'b0);
        step();
        drive(1, 1'b1, 7'h04, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_value("t5_blocked_r0", obs_ready0, 1'b0);
            check_value("t5_served_r1", obs_ready1, 1'b1);
        end
        in_rsp_ready[0] = 1'b1;
        drive(0, 1'b1, 7'h08, 1'b0, 32'h0, 1'b0);
        step();
        check_value("t5_release_r0", obs_ready0, 1'b1);
        check_value("t5_reload", rsp0_rdata, 32'hDEAD_BEEF);
        idle_all();

        // Asynchronous reset while LOCKED1 with a pending rsp1.
        in_rsp_ready[1] = 1'b0;
        drive(1, 1'b1, 7'h08, 1'b0, 32'h0, 1'b1);
        step();
        check_value("t6_pre_rsp1", rsp1_valid, 1'b1);
        drive(0, 1'b1, 7'h00, 1'b1, 32'h5555_AAAA, 1'b0);
        drive(1, 1'b1, 7'h04, 1'b1, 32'hAAAA_5555, 1'b0);
        rst = 1'b0;
        #1;
        check_value("t6_rst_rsp0", rsp0_valid, 1'b0);
        check_value("t6_rst_rsp1", rsp1_valid, 1'b0);
        check_value("t6_rst_mem_we", mem_we, 1'b0);
        check_value("t6_rst_ready0", req0_ready, 1'b0);
        check_value("t6_rst_ready1", req1_ready, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        in_rsp_ready[1] = 1'b1;
        step();
        check_value("t6_first_tie_r0", obs_ready0, 1'b1);
        idle_all();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                logic [AW-1:0] a;
                if ($urandom_range(0, 3) != 0) a = AW'($urandom_range(0, DEPTH - 1) * 4);
                else                           a = AW'($urandom_range(0, 127));
                drive(n, $urandom_range(0, 2) != 0, a, $urandom_range(0, 1) == 1,
                      $urandom(), $urandom_range(0, 3) == 0);
                in_rsp_ready[n] = $urandom_range(0, 3) != 0;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-ported data memory between requester 0 (core load/store unit) and requester 1 (debug/DMA port).
- Sits directly in front of the data memory. Drives its address, write-enable and write-data inputs, and samples its combinational read data.
- Provides round-robin arbitration, a lock for atomic read-modify-write sequences, alignment/range error checking, and a registered per-requester response with backpressure.

Parameters:
- DATA_W, 32, data width in bits.
- ADDR_W, 6, byte-address width on requester and memory side.
- MEM_DEPTH, 16, number of DATA_W words in the memory; word index = addr >> 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- reqN_valid  in  1  requester N (N=0,1) has a request.
- reqN_ready  out  1  request accepted this cycle (valid & ready).
- reqN_addr  in  ADDR_W  byte address.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_wdata  in  DATA_W  write data.
- reqN_lock  in  1  keep grant after this access.
- rspN_valid  out  1  response available.
- rspN_ready  in  1  requester consumes response.
- rspN_rdata  out  DATA_W  read data (0 for writes or errors).
- rspN_err  out  1  misaligned or out-of-range access.
- mem_addr  out  ADDR_W  to memory address.
- mem_we  out  1  to memory write enable.
- mem_wdata  out  DATA_W  to memory write data.
- mem_rdata  in  DATA_W  from memory read data (combinational from storage).

Behaviour:
- Reset (rst=0, async):
  - rspN_valid=0, rspN_rdata=0, rspN_err=0.
  - lock state UNLOCKED, last_grant=1, so requester 0 wins the first tie.
  - mem_we=0 and reqN_ready=0 while in reset.
  - An in-flight response is discarded.
- Eligibility: requester N is eligible when reqN_valid=1 and its response slot is free (rspN_valid=0 or rspN_ready=1 in the same cycle).
- Lock FSM (states UNLOCKED, LOCKED0, LOCKED1):
  - UNLOCKED, one eligible requester: it wins.
  - UNLOCKED, both eligible: the requester not equal to last_grant wins.
  - LOCKEDn: only requester n may win. The other requester's ready is held 0 even if requester n is idle.
  - Transition on every accepted access by winner w:
    - lock=1 moves the FSM to LOCKEDw.
    - lock=0 moves it to UNLOCKED.
  - last_grant updates to w.
- Issue (combinational, same cycle as acceptance):
  - reqw_ready=1, mem_addr=reqw_addr, mem_wdata=reqw_wdata.
  - mem_we = reqw_we & ~err.
  - Loser ready=0.
  - No winner: mem_we=0, mem_addr/mem_wdata=0.
- Error: err = (addr[1:0]!=0) | ((addr>>2) >= MEM_DEPTH).
  - An error access is still accepted and still completes.
  - The memory is not written.
  - The response carries err=1 and rdata=0.
- Response (latency 1):
  - At the accept edge, rspw_valid<=1, rspw_err<=err.
  - rspw_rdata<=mem_rdata for a good read, otherwise 0.
  - A read returns the value stored before that edge.
  - rspN_valid clears on the edge where rspN_ready=1, unless a new access by N is accepted that cycle; then it reloads.
  - rspN_rdata/err hold while valid and not ready.
- Ordering:
  - A write followed by a read of the same word on any later cycle returns the new data.
  - At most one memory access per cycle; at most one outstanding response per requester.
- Throughput: one access per cycle sustained if the response is consumed every cycle.

Test Plan:
- Reset, then req0 write addr 0x08 data 0xDEADBEEF, next cycle req0 read 0x08 -> rsp0_valid one cycle after each accept; read rdata=0xDEADBEEF, err=0.
- Both requesters valid continuously, reading 0x00/0x04, responses always ready -> grants alternate 0,1,0,1 starting with 0; each rsp appears one cycle after its accept.
- req1 read 0x10 with lock=1, then write 0x10 with lock=0 while req0 valid throughout -> req0_ready=0 for both cycles; req0 granted the cycle after the unlock write.
- req0 write to misaligned addr 0x06, then to addr 0x40 (index 16) -> both accepted, mem_we=0, rsp0_err=1, rdata=0; a later read of 0x04 is unchanged.
- rsp0_ready held 0 with rsp0_valid=1, req0 valid -> req0_ready=0 and req1 still served; release rsp0_ready -> req0 accepted in the same cycle, rsp0 reloads next cycle.
- Assert rst=0 mid-stream while rsp1_valid=1 and state LOCKED1 -> immediately rsp valids=0, mem_we=0; after release, req0 wins the first tie.
